// File: rtl/cmd_tx_if.sv
// Requester/issue bundle for cmd_tx: command request handshake, flush,
// issued-command strobe, FIFO level and the issue FSM state for debug.
interface cmd_tx_if;
    // Handshake: a command transfers at a rising edge where req_valid and
    // req_ready are both 1; req_ready is registered and the requester holds
    // its command while req_ready is 0.
    logic        req_valid;
    logic [4:0]  req_addr;
    logic [2:0]  req_op;
    logic [3:0]  req_d;
    logic        req_ready;
    logic        flush;
    logic        new_cmd;
    logic [11:0] cmd_buf;
    logic [3:0]  level;
    logic [1:0]  issue_state;

    modport slave (
        input  req_valid, req_addr, req_op, req_d, flush,
        output req_ready, new_cmd, cmd_buf, level, issue_state
    );

    modport master (
        output req_valid, req_addr, req_op, req_d, flush,
        input  req_ready, new_cmd, cmd_buf, level, issue_state
    );
endinterface

// File: rtl/cmd_tx.sv
// Command FIFO with a rate-limited issue FSM: one new_cmd strobe per GAP cycles.
// Optional macro CMD_TX_DROP_NOP_EN: acknowledge op 3'b000 requests without queueing them.
module cmd_tx #(
    parameter int DEPTH = 4,
    parameter int GAP   = 4
) (
    input  logic     clk,
    input  logic     rst,
    cmd_tx_if.slave  cmd_io
);
    localparam int PW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STROBE = 2'd1,
        S_GAP    = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    gap_q, gap_d;
    logic [11:0]   mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [3:0]    count_q, count_d;
    logic          ready_q, ready_d;
    logic [11:0]   cmd_buf_q, cmd_buf_d;
    logic [11:0]   req_word;
    logic          accept, push, pop, issue_slot, new_cmd;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign req_word = {cmd_io.req_addr, cmd_io.req_op, cmd_io.req_d};
    assign accept   = cmd_io.req_valid & ready_q;
`ifdef CMD_TX_DROP_NOP_EN
    assign push     = accept & ~cmd_io.flush & (cmd_io.req_op != 3'b000);
`else
    assign push     = accept & ~cmd_io.flush;
`endif

    // An expiring gap counter acts as an IDLE cycle so backlogged strobes land exactly GAP apart.
    assign issue_slot = (state_q == S_IDLE) || ((state_q == S_GAP) && (gap_q == 4'd0));
    assign pop        = issue_slot & (count_q != 4'd0) & ~cmd_io.flush;

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        cmd_buf_d = cmd_buf_q;
        if (cmd_io.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = next_ptr(wr_ptr_q);
            if (pop) begin
                rd_ptr_d  = next_ptr(rd_ptr_q);
                cmd_buf_d = mem_q[rd_ptr_q];
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 4'd1;
                2'b01:   count_d = count_q - 4'd1;
                default: count_d = count_q;
            endcase
        end
        ready_d = (count_d != 4'(DEPTH));
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= req_word;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            ready_q   <= 1'b1;
            cmd_buf_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            ready_q   <= ready_d;
            cmd_buf_q <= cmd_buf_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            gap_q   <= gap_d;
        end
    end

    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        case (state_q)
            S_IDLE: begin
                if (pop) state_d = S_STROBE;
            end
            S_STROBE: begin
                state_d = S_GAP;
                gap_d   = 4'(GAP - 2);
            end
            S_GAP: begin
                if (gap_q == 4'd0) state_d = pop ? S_STROBE : S_IDLE;
                else               gap_d   = gap_q - 4'd1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        new_cmd = (state_q == S_STROBE);
    end

    assign cmd_io.new_cmd     = new_cmd;
    assign cmd_io.cmd_buf     = cmd_buf_q;
    assign cmd_io.level       = count_q;
    assign cmd_io.req_ready   = ready_q;
    assign cmd_io.issue_state = state_q;
endmodule

// File: tb/tb_cmd_tx.sv
// Bench for cmd_tx: table-driven command vectors plus hand-written sequences
// for latency, full FIFO, flush, mid-gap reset and NOP handling.
module tb_cmd_tx;
    localparam int DEPTH = 4;
    localparam int GAP   = 4;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_GAP  = 2'd2;

    typedef struct {
        logic [4:0]  addr;
        logic [2:0]  op;
        logic [3:0]  d;
        logic [11:0] exp_word;
    } vec_t;

    logic clk;
    logic rst;
    cmd_tx_if bus();

    cmd_tx #(.DEPTH(DEPTH), .GAP(GAP)) dut (
        .clk    (clk),
        .rst    (rst),
        .cmd_io (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int strobe_cnt = 0;
    int last_cyc   = 0;
    bit have_last  = 0;
    logic [3:0]  max_level = 0;
    logic [11:0] exp_q[$];
    int          strobe_t[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name, input logic [31:0] act);
        n_tests++;
        n_fail++;
        $display("FAIL %s: got 0x%0h, expected none (cycle %0d)", name, act, cyc);
    endtask

    // Scoreboard: every strobe must match the oldest outstanding command.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.level > max_level) max_level = bus.level;
            if (bus.new_cmd) begin
                strobe_cnt++;
                strobe_t.push_back(cyc);
                if (have_last) check("strobe_spacing_ge_gap", 32'(cyc - last_cyc >= GAP), 32'd1);
                last_cyc  = cyc;
                have_last = 1'b1;
                if (exp_q.size() == 0) fail_now("unexpected_strobe", 32'(bus.cmd_buf));
                else check("cmd_buf_order", 32'(bus.cmd_buf), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic send(input logic [4:0] a, input logic [2:0] o, input logic [3:0] dd,
                        input logic [11:0] word, input bit will_issue);
        int waited = 0;
        bus.req_addr  = a;
        bus.req_op    = o;
        bus.req_d     = dd;
        bus.req_valid = 1'b1;
        while (!bus.req_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.req_ready) fail_now("send_ready_timeout", 32'(word));
        else if (will_issue) exp_q.push_back(word);
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
    endtask

    task automatic send_rand(output logic [11:0] word);
        logic [4:0] a;
        logic [2:0] o;
        logic [3:0] dd;
        a  = 5'($urandom_range(0, 31));
        o  = 3'($urandom_range(1, 7));
        dd = 4'($urandom_range(0, 15));
        word = {a, o, dd};
        send(a, o, dd, word, 1'b1);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain_outstanding", 32'(exp_q.size()), 32'd0);
        repeat (GAP + 2) @(negedge clk);
        check("drain_idle_state", 32'(bus.issue_state), 32'(ST_IDLE));
        check("drain_level", 32'(bus.level), 32'd0);
    endtask

    initial begin
        vec_t        vecs[4];
        logic [11:0] w0, w1, w2;
        int          s0;

        vecs[0] = '{5'h0D, 3'b101, 4'h3, 12'h6D3};
        vecs[1] = '{5'h1F, 3'b111, 4'hF, 12'hFFF};
        vecs[2] = '{5'h00, 3'b001, 4'h0, 12'h010};
        vecs[3] = '{5'h15, 3'b010, 4'hA, 12'hAAA};

        rst = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_addr  = '0;
        bus.req_op    = '0;
        bus.req_d     = '0;
        bus.flush     = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_ready", 32'(bus.req_ready), 32'd1);
        check("rst_level", 32'(bus.level), 32'd0);
        check("rst_new_cmd", 32'(bus.new_cmd), 32'd0);
        check("rst_cmd_buf", 32'(bus.cmd_buf), 32'h000);
        check("rst_state", 32'(bus.issue_state), 32'(ST_IDLE));

        // Latency: accepted at the first edge after reset, strobe after edge N+1.
        rst = 1'b0;
        bus.req_addr  = 5'h0C;
        bus.req_op    = 3'b101;
        bus.req_d     = 4'h3;
        bus.req_valid = 1'b1;
        exp_q.push_back(12'h653);
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(negedge clk);
        check("lat_level_after_n", 32'(bus.level), 32'd1);
        check("lat_no_strobe_n", 32'(bus.new_cmd), 32'd0);
        @(negedge clk);
        check("lat_strobe_n1", 32'(bus.new_cmd), 32'd1);
        check("lat_cmd_buf", 32'(bus.cmd_buf), 32'h653);
        check("lat_level_zero", 32'(bus.level), 32'd0);
        @(negedge clk);
        check("lat_strobe_one_cycle", 32'(bus.new_cmd), 32'd0);
        check("lat_cmd_buf_hold", 32'(bus.cmd_buf), 32'h653);
        drain();

        // Table vectors back-to-back: strobes exactly GAP apart, level peaks at 3.
        s0 = strobe_cnt;
        strobe_t.delete();
        max_level = 0;
        for (int i = 0; i < 4; i++) send(vecs[i].addr, vecs[i].op, vecs[i].d, vecs[i].exp_word, 1'b1);
        drain();
        check("table_strobe_count", 32'(strobe_cnt - s0), 32'd4);
        check("table_max_level", 32'(max_level), 32'd3);
        if (strobe_t.size() == 4) begin
            for (int i = 1; i < 4; i++) check("table_spacing_eq_gap", 32'(strobe_t[i] - strobe_t[i-1]), 32'(GAP));
        end else begin
            fail_now("table_strobe_times", 32'(strobe_t.size()));
        end

        // Full FIFO: held request is refused on the pop edge, accepted one edge later.
        s0 = strobe_cnt;
        for (int i = 0; i < 5; i++) send_rand(w0);
        @(negedge clk);
        check("full_level", 32'(bus.level), 32'd4);
        check("full_ready", 32'(bus.req_ready), 32'd0);
        check("full_state_gap", 32'(bus.issue_state), 32'(ST_GAP));
        bus.req_addr  = 5'h12;
        bus.req_op    = 3'b011;
        bus.req_d     = 4'h5;
        bus.req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("full_pop_no_accept", 32'(bus.level), 32'd3);
        check("full_ready_back", 32'(bus.req_ready), 32'd1);
        exp_q.push_back(12'h935);
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(negedge clk);
        check("full_held_accepted", 32'(bus.level), 32'd4);
        drain();
        check("full_strobe_count", 32'(strobe_cnt - s0), 32'd6);

        // Flush during GAP after the first strobe, with a simultaneous request dropped.
        s0 = strobe_cnt;
        send_rand(w0);
        send_rand(w1);
        send_rand(w2);
        bus.flush     = 1'b1;
        bus.req_addr  = 5'h01;
        bus.req_op    = 3'b001;
        bus.req_d     = 4'h1;
        bus.req_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.flush     = 1'b0;
        bus.req_valid = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("flush_level", 32'(bus.level), 32'd0);
        check("flush_ready", 32'(bus.req_ready), 32'd1);
        repeat (3 * GAP) @(negedge clk);
        check("flush_strobe_count", 32'(strobe_cnt - s0), 32'd1);
        check("flush_cmd_buf_keep", 32'(bus.cmd_buf), 32'(w0));
        check("flush_level_stays", 32'(bus.level), 32'd0);
        check("flush_state_idle", 32'(bus.issue_state), 32'(ST_IDLE));

        // Asynchronous reset mid-GAP with two commands queued.
        send_rand(w0);
        send_rand(w1);
        send_rand(w2);
        @(negedge clk);
        check("pre_rst_level", 32'(bus.level), 32'd2);
        check("pre_rst_state", 32'(bus.issue_state), 32'(ST_GAP));
        #2 rst = 1'b1;
        #1;
        check("rst_mid_new_cmd", 32'(bus.new_cmd), 32'd0);
        check("rst_mid_cmd_buf", 32'(bus.cmd_buf), 32'h000);
        check("rst_mid_level", 32'(bus.level), 32'd0);
        check("rst_mid_ready", 32'(bus.req_ready), 32'd1);
        check("rst_mid_state", 32'(bus.issue_state), 32'(ST_IDLE));
        exp_q.delete();
        have_last = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        send_rand(w0);
        @(negedge clk);
        check("post_rst_first_accept", 32'(bus.level), 32'd1);
        drain();

        // NOP opcode handling.
        s0 = strobe_cnt;
`ifdef CMD_TX_DROP_NOP_EN
        send(5'h0C, 3'b000, 4'h0, 12'h600, 1'b0);
        send(5'h0C, 3'b110, 4'h0, 12'h660, 1'b1);
        drain();
        check("nop_strobe_count", 32'(strobe_cnt - s0), 32'd1);
`else
        send(5'h0C, 3'b000, 4'h0, 12'h600, 1'b1);
        send(5'h0C, 3'b110, 4'h0, 12'h660, 1'b1);
        drain();
        check("nop_strobe_count", 32'(strobe_cnt - s0), 32'd2);
`endif
        check("nop_last_cmd_buf", 32'(bus.cmd_buf), 32'h660);

        check("final_outstanding", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
